// File: rtl/axis_uart_tx_fifo.sv
// axis_uart_tx_fifo: AXI-Stream byte sink feeding a 2**FIFO_AW deep FIFO that
// drains into a UART serialiser (start, 8 data bits LSB first, stop bits).
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit after D7.
// Handshake: a byte is taken on a rising edge where i_tvalid && i_tready;
// i_tready depends only on the registered FIFO level, never on a same-cycle pop.
module axis_uart_tx_fifo #(
    parameter int FIFO_AW   = 4,
    parameter int CLKDIV    = 100,
    parameter int STOP_BITS = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         i_tdata,
    input  logic               i_tvalid,
    output logic               i_tready,
    output logic               tx,
    output logic               busy,
    output logic [FIFO_AW:0]   o_level
);

    localparam int                 DEPTH    = 1 << FIFO_AW;
    localparam int                 CW       = $clog2(CLKDIV);
    localparam logic [FIFO_AW:0]   DEPTH_L  = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0]   LVL_ONE  = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);
    localparam logic [CW-1:0]      CNT_LOAD = CW'(CLKDIV - 1);
    localparam logic [CW-1:0]      CNT_ONE  = CW'(1);
    localparam logic               STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    logic [7:0]         r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wptr;
    logic [FIFO_AW-1:0] r_rptr;
    logic [FIFO_AW:0]   r_level;

    // r_state is the observable FSM state for checkers and waveform viewers.
    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shreg;
    logic               r_stop_idx;
    logic               r_tx;

    logic               w_push;
    logic               w_pop;
    logic               w_bit_end;
    logic               w_last_stop;

    assign i_tready    = (r_level != DEPTH_L);
    assign w_push      = i_tvalid && i_tready;
    assign w_bit_end   = (r_cnt == '0);
    assign w_last_stop = (r_state == S_STOP) && w_bit_end && (r_stop_idx == STOP_LAST);
    assign w_pop       = (r_level != '0) && ((r_state == S_IDLE) || w_last_stop);

    assign tx      = r_tx;
    assign busy    = (r_state != S_IDLE) || (r_level != '0);
    assign o_level = r_level;

    // FIFO storage: written on accepted handshakes, contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_tdata;
        end
    end

    // FIFO pointers and occupancy; a simultaneous push and pop leaves the level unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_ONE;
                2'b01:   r_level <= r_level - LVL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    // Frame sequencer: every bit lasts CLKDIV cycles, tx is driven from a register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_bit_idx  <= '0;
            r_shreg    <= '0;
            r_stop_idx <= 1'b0;
            r_tx       <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_state <= S_START;
                        r_cnt   <= CNT_LOAD;
                        r_shreg <= r_mem[r_rptr];
                        r_tx    <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_state   <= S_DATA;
                        r_cnt     <= CNT_LOAD;
                        r_bit_idx <= 3'd0;
                        r_tx      <= r_shreg[0];
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= CNT_LOAD;
                        if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            r_state <= S_PARITY;
                            r_tx    <= ^r_shreg;
`else
                            r_state    <= S_STOP;
                            r_stop_idx <= 1'b0;
                            r_tx       <= 1'b1;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_tx      <= r_shreg[r_bit_idx + 3'd1];
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_state    <= S_STOP;
                        r_cnt      <= CNT_LOAD;
                        r_stop_idx <= 1'b0;
                        r_tx       <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
`endif
                S_STOP: begin
                    if (w_bit_end) begin
                        if (r_stop_idx != STOP_LAST) begin
                            r_stop_idx <= r_stop_idx + 1'b1;
                            r_cnt      <= CNT_LOAD;
                        end else if (w_pop) begin
                            // Next byte waiting: start bit follows with no idle cycle.
                            r_state <= S_START;
                            r_cnt   <= CNT_LOAD;
                            r_shreg <= r_mem[r_rptr];
                            r_tx    <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                            r_tx    <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_uart_tx_fifo.sv
// tb_axis_uart_tx_fifo: directed stimulus with a scoreboard queue of expected
// bytes; a line monitor decodes tx frames and compares them against the queue.
module tb_axis_uart_tx_fifo;

    localparam int CLKDIV    = 4;
    localparam int STOP_BITS = 1;
    localparam int FIFO_AW   = 4;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FRAME = (1 + 8 + PAR + STOP_BITS) * CLKDIV;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [7:0]       i_tdata = 8'h00;
    logic             i_tvalid = 1'b0;
    logic             i_tready;
    logic             tx;
    logic             busy;
    logic [FIFO_AW:0] o_level;

    axis_uart_tx_fifo #(
        .FIFO_AW  (FIFO_AW),
        .CLKDIV   (CLKDIV),
        .STOP_BITS(STOP_BITS)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .i_tdata (i_tdata),
        .i_tvalid(i_tvalid),
        .i_tready(i_tready),
        .tx      (tx),
        .busy    (busy),
        .o_level (o_level)
    );

    // clock / reset
    always #5 clk = ~clk;

    // scoreboard state
    logic [7:0] exp_q[$];
    int         start_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_frames = 0;

    // driver bookkeeping for the fill test
    int         fill_accepted   = 0;
    int         n_refused       = 0;
    int         first_refuse_at = -1;
    int         n_full_pops     = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // line monitor: decodes one frame, checks every cycle of every bit
    int         cyc_cnt  = 0;
    bit         m_active = 1'b0;
    int         m_cyc    = 0;
    int         m_glitch = 0;
    int         m_stop_bad = 0;
    logic [7:0] m_data   = 8'h00;
    logic       m_par    = 1'b0;
    logic [7:0] m_exp;

    always @(negedge clk) begin
        int b;
        int ph;
        cyc_cnt++;
        if (rst) begin
            m_active = 1'b0;
        end else begin
            if (!m_active && tx == 1'b0) begin
                m_active   = 1'b1;
                m_cyc      = 0;
                m_glitch   = 0;
                m_stop_bad = 0;
                m_data     = 8'h00;
                m_par      = 1'b0;
                start_q.push_back(cyc_cnt);
            end
            if (m_active) begin
                b  = m_cyc / CLKDIV;
                ph = m_cyc % CLKDIV;
                if (b == 0) begin
                    if (tx !== 1'b0) m_glitch++;
                end else if (b <= 8) begin
                    if (ph == 0) m_data[b-1] = tx;
                    else if (tx !== m_data[b-1]) m_glitch++;
                end else if (PAR == 1 && b == 9) begin
                    if (ph == 0) m_par = tx;
                    else if (tx !== m_par) m_glitch++;
                end else begin
                    if (tx !== 1'b1) m_stop_bad++;
                end
                if (m_cyc == FRAME - 1) begin
                    n_frames++;
                    if (exp_q.size() == 0) begin
                        check("frame_pending", exp_q.size(), 1);
                    end else begin
                        m_exp = exp_q.pop_front();
                        check("frame_data", {24'h0, m_data}, {24'h0, m_exp});
                        check("frame_shape", m_glitch + m_stop_bad, 0);
`ifdef UART_TX_PARITY_EN
                        check("frame_parity", {31'h0, m_par}, {31'h0, ^m_exp});
`endif
                    end
                    m_active = 1'b0;
                end
                m_cyc++;
            end
        end
    end

    // driver: present a byte at the negedge, hold until accepted
    task automatic push_byte(input logic [7:0] b);
        bit               acc;
        int               n;
        logic [FIFO_AW:0] lvl_before;
        n = 0;
        @(negedge clk);
        i_tdata  = b;
        i_tvalid = 1'b1;
        forever begin
            acc        = i_tready;
            lvl_before = o_level;
            @(posedge clk);
            #1;
            if (acc) break;
            if (n_refused == 0) first_refuse_at = fill_accepted;
            n_refused++;
            check("ready_low_only_at_full", {27'h0, lvl_before}, 32'd16);
            if (o_level != lvl_before) begin
                n_full_pops++;
                check("full_pop_level", {27'h0, o_level}, {27'h0, lvl_before} - 32'd1);
            end
            n++;
            if (n > 200) begin
                check("push_timeout", {31'h0, i_tready}, 32'd1);
                break;
            end
            @(negedge clk);
        end
        i_tvalid = 1'b0;
        if (acc) begin
            exp_q.push_back(b);
            fill_accepted++;
        end
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (busy && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (busy) check("idle_timeout", {31'h0, busy}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // main sequence
    initial begin
        int cnt;
        int s1;
        int s2;

        // reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", {31'h0, tx}, 32'd1);
        check("rst_busy", {31'h0, busy}, 32'd0);
        check("rst_level", {27'h0, o_level}, 32'd0);
        check("rst_tready", {31'h0, i_tready}, 32'd1);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // single byte 0xA5: start bit on the edge after the handshake
        push_byte(8'hA5);
        check("single_level_after_push", {27'h0, o_level}, 32'd1);
        check("single_tx_still_idle", {31'h0, tx}, 32'd1);
        @(posedge clk);
        #1;
        check("single_start_tx", {31'h0, tx}, 32'd0);
        check("single_level_after_pop", {27'h0, o_level}, 32'd0);
        check("single_busy", {31'h0, busy}, 32'd1);
        cnt = 0;
        while (busy && cnt < 200) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check("single_busy_cycles", cnt, FRAME);
        wait_idle(100);

        // fill and overflow: 20 bytes while the line is busy
        fill_accepted = 0;
        n_refused     = 0;
        n_full_pops   = 0;
        for (int i = 0; i < 20; i++) begin
            push_byte(8'(i));
        end
        check("fill_first_refusal_after", first_refuse_at, 17);
        check("fill_full_pops", n_full_pops, 3);
        wait_idle(2000);

        // back-to-back frames
        push_byte(8'h55);
        push_byte(8'hAA);
        wait_idle(500);
        s2 = start_q[start_q.size() - 1];
        s1 = start_q[start_q.size() - 2];
        check("b2b_start_spacing", s2 - s1, FRAME);

        // reset during D3 of 0xF0 with three bytes queued
        push_byte(8'hF0);
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        repeat (16) @(negedge clk);
        check("pre_reset_tx_d3", {31'h0, tx}, 32'd0);
        check("pre_reset_level", {27'h0, o_level}, 32'd3);
        #1;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("mid_reset_tx", {31'h0, tx}, 32'd1);
        check("mid_reset_level", {27'h0, o_level}, 32'd0);
        check("mid_reset_busy", {31'h0, busy}, 32'd0);
        check("mid_reset_tready", {31'h0, i_tready}, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("post_reset_tx", {31'h0, tx}, 32'd1);
        push_byte(8'h3C);
        wait_idle(500);

`ifdef UART_TX_PARITY_EN
        // parity: 0x07 has odd weight (bit 1), 0x03 even weight (bit 0)
        push_byte(8'h07);
        wait_idle(500);
        push_byte(8'h03);
        wait_idle(500);
`endif

        // drain accounting
        check("scoreboard_empty", exp_q.size(), 0);
        check("frames_completed", n_frames, 1 + 20 + 2 + 1 + 2 * PAR);
        check("final_tx_idle", {31'h0, tx}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // watchdog
    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/axis_uart_tx_fifo.md
# axis_uart_tx_fifo

AXI-Stream-to-UART transmitter with an internal byte FIFO. It is the transmit-side counterpart of the AXI-Stream UART receive path. It accepts bytes from an AXI-Stream master and serialises them as 8N1 frames (8E1 with parity compiled in) on a single TX line. It sits between packet-producing logic and the FTDI USB-UART pin in the Posedge top levels.

## Interface
- FIFO_AW, 4: FIFO address width. Depth = 2**FIFO_AW bytes (16 by default).
- CLKDIV, 100: clk cycles per UART bit. Legal range ≥ 2.
- STOP_BITS, 1: number of stop bits. Legal values are 1 or 2.

- clk  in  1  single system clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- i_tdata  in  8  byte to transmit.
- i_tvalid  in  1  AXI-Stream valid.
- i_tready  out  1  AXI-Stream ready. Equals (level != depth).
- tx  out  1  serial line; idles high.
- busy  out  1  high while a frame is on the line or the FIFO is non-empty.
- o_level  out  FIFO_AW+1  current FIFO occupancy, 0..depth.

## Operation
- Reset values while rst is high: tx=1, busy=0, o_level=0, i_tready=1, FSM=IDLE, baud counter=0, FIFO pointers=0. Handshakes are not accepted while rst is high.
- Push: a byte is written on any rising edge where i_tvalid && i_tready. i_tready is decoded from the registered count only. It does not depend on a same-cycle pop, so a full FIFO deasserts ready even while popping.
- Pop: happens only in IDLE, or at the last cycle of the final stop bit, when level != 0. The byte is loaded into the shift register. There is no write-to-read bypass: a byte pushed into an empty FIFO is popped on the following edge.
- Simultaneous push and pop: level is unchanged. Pointers wrap modulo depth. Level arithmetic is FIFO_AW+1 bits wide and never exceeds depth.
- FSM states are IDLE → START → DATA → (PARITY) → STOP → IDLE or START.
  - START: tx=0.
  - DATA: 8 bits, LSB first, 3-bit bit index.
  - PARITY: present only when the parity feature is compiled in.
  - STOP: tx=1 for STOP_BITS bit times.
- Baud counter: loads CLKDIV-1 on entry to each bit and counts down. The bit ends when the counter reaches 0, so every bit lasts exactly CLKDIV cycles.
- End of STOP: if level != 0, pop and go straight to START with no idle cycle between frames. Otherwise go to IDLE.
- tx is registered and glitch-free.
- busy = (state != IDLE) || (level != 0).
- Reset mid-frame: tx returns to 1 immediately (asynchronously). The partial frame and all FIFO contents are discarded.

## Timing
- Handshake at edge N into an empty, idle block: the pop happens at edge N+1, and tx=0 is visible after edge N+1.
- Frame length: (1 + 8 + P + STOP_BITS) × CLKDIV cycles, where P=1 with parity and 0 without. Default 8N1 at CLKDIV=100 is 1000 cycles.
- Back-to-back frames: the next start bit begins on the cycle immediately after the last stop-bit cycle.
- o_level updates on the edge after the push or pop. i_tready follows o_level combinationally.

## Configuration
- UART_TX_PARITY_EN defined: an even-parity bit (XOR of the 8 data bits) is inserted after D7 for one bit time. Frames become 8E1/8E2.
- UART_TX_PARITY_EN undefined: there is no PARITY state and frames are 8N1/8N2. The parity logic is absent from the netlist.

## Test plan
- Single byte, CLKDIV=4, 8N1: push 0xA5 at edge N. Required: tx low from N+1 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high. busy drops after 40 cycles.
- Fill and overflow: hold i_tvalid with 20 bytes 0x00..0x13 while tx is stalled behind a long frame. Required: i_tready drops at o_level=16. No byte is lost or duplicated, and the line decodes 0x00..0x13 in order.
- Back-to-back: push 0x55 and 0xAA on consecutive cycles. Required: the second start bit begins exactly 10×CLKDIV cycles after the first, with no idle gap.
- Simultaneous push and pop at full: hold the FIFO full and push on the exact cycle of a pop. Required: the push is not accepted (i_tready=0) and o_level goes 16→15.
- Reset mid-frame: assert rst during D3 of 0xF0 with 3 bytes queued. Required: tx=1 immediately, o_level=0, busy=0. The next pushed byte 0x3C transmits cleanly.
- Parity (UART_TX_PARITY_EN defined): push 0x07. Required: the parity bit is 1 and the frame length is 11×CLKDIV. For 0x03, the parity bit is 0.
